piso_stream_ser: RTL and testbench

Parametrised parallel-in/serial-out serializer. It accepts DW-bit words over a valid/ready handshake and shifts each word out one bit per enabled clock, LSB-first or MSB-first, selected per word. A one-entry hold buffer allows gapless back-to-back words. Frame markers (first/last/done) are provided for downstream framing logic in serial link datapaths.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_hold_buf.sv | 43 ++++
 rtl/piso_stream_ser.sv | 125 ++++++++++++
 tb/tb_piso_stream_ser.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream_ser serializer.
// Holds the FSM state encoding and the bit-counter width helper.
package piso_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of the bit counter; a single-bit word still needs one counter bit.
    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry hold register (word + bit-order mode) with a valid flag.
// Lets the next word wait while the current one is still shifting out.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          unload,
    input  logic [DW-1:0] in_data,
    input  logic          in_mode,
    output logic [DW-1:0] data,
    output logic          mode,
    output logic          valid
);

    logic [DW-1:0] data_reg;
    logic          mode_reg;
    logic          valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg  <= '0;
            mode_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                data_reg  <= in_data;
                mode_reg  <= in_mode;
                valid_reg <= 1'b1;
            end else if (unload) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data  = data_reg;
    assign mode  = mode_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in/serial-out serializer with valid/ready input, per-word bit order,
// a one-word hold buffer for gapless streaming, and first/last/done frame markers.
module piso_stream_ser
    import piso_pkg::*;
#(
    parameter int DW          = 8,
    parameter bit LSB_DEFAULT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          msb_first,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          ser_first,
    output logic          ser_last,
    output logic          busy,
    output logic          done
);

    localparam int            CW       = cnt_w(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t        state_reg, state_next;
    logic [DW-1:0] sreg_reg, sreg_next;
    logic          mode_reg, mode_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          done_reg;

    logic [DW-1:0] hold_data;
    logic          hold_mode;
    logic          hold_valid;

    logic          accept;
    logic          at_last;
    logic          direct_load;
    logic          hold_load;
    logic          hold_unload;

    // in_ready is held low while reset is asserted, not just after it.
    assign in_ready    = rst && enb && !hold_valid;
    assign accept      = in_valid && in_ready;
    assign at_last     = (state_reg == ST_SHIFT) && (cnt_reg == CNT_LAST);
    // An accepted word implies the hold buffer is empty, so only the FSM position decides.
    assign direct_load = accept && ((state_reg == ST_IDLE) || at_last);
    assign hold_load   = accept && !direct_load;
    assign hold_unload = enb && at_last && hold_valid;

    piso_hold_buf #(
        .DW (DW)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .unload  (hold_unload),
        .in_data (in_data),
        .in_mode (msb_first),
        .data    (hold_data),
        .mode    (hold_mode),
        .valid   (hold_valid)
    );

    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        if (enb) begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = ST_SHIFT;
                        sreg_next  = in_data;
                        mode_next  = msb_first;
                        cnt_next   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (!at_last) begin
                        sreg_next = mode_reg ? (sreg_reg << 1) : (sreg_reg >> 1);
                        cnt_next  = cnt_reg + CW'(1);
                    end else if (hold_valid) begin
                        sreg_next = hold_data;
                        mode_next = hold_mode;
                        cnt_next  = '0;
                    end else if (accept) begin
                        sreg_next = in_data;
                        mode_next = msb_first;
                        cnt_next  = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            sreg_reg  <= '0;
            mode_reg  <= !LSB_DEFAULT;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            done_reg  <= ser_last;
        end
    end

    assign ser_out   = mode_reg ? sreg_reg[DW-1] : sreg_reg[0];
    assign ser_valid = (state_reg == ST_SHIFT) && enb;
    assign ser_first = ser_valid && (cnt_reg == '0);
    assign ser_last  = ser_valid && (cnt_reg == CNT_LAST);
    assign done      = done_reg && enb;
    assign busy      = (state_reg == ST_SHIFT) || hold_valid;

endmodule

// File: tb/tb_piso_stream_ser.sv
// Self-checking bench for piso_stream_ser: fixed word vectors, multi-cycle corner
// sequences, and a randomized run against a bit-queue reference model.
module tb_piso_stream_ser;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          msb_first;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_first;
    logic          ser_last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_stream_ser #(
        .DW          (DW),
        .LSB_DEFAULT (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msb_first (msb_first),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [0:7] seq;   // seq[i] = expected ser_out in cycle i+1
    } vec_t;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } sbit_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        enb      = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t       vecs [6];
    sbit_t      q [$];
    logic [0:7]  sq;
    logic [0:15] sq16;
    logic        exp_ready;
    logic        prev_last;
    int          b;

    initial begin
        vecs[0] = '{data: 8'hC1, msb: 1'b0, seq: 8'b10000011};
        vecs[1] = '{data: 8'h3A, msb: 1'b1, seq: 8'b00111010};
        vecs[2] = '{data: 8'hA5, msb: 1'b0, seq: 8'b10100101};
        vecs[3] = '{data: 8'hA5, msb: 1'b1, seq: 8'b10100101};
        vecs[4] = '{data: 8'h01, msb: 1'b1, seq: 8'b00000001};
        vecs[5] = '{data: 8'h80, msb: 1'b0, seq: 8'b00000001};

        rst = 1'b0; enb = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0;
        mid();
        chk("rst_ready",  in_ready,  1'b0);
        chk("rst_valid",  ser_valid, 1'b0);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_done",   done,      1'b0);
        chk("rst_serout", ser_out,   1'b0);
        step();
        rst = 1'b1;
        mid();
        chk("rel_ready", in_ready, 1'b1);
        step();

        // Single-word vectors
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1; in_data = vecs[v].data; msb_first = vecs[v].msb;
            mid();
            chk("vec_ready", in_ready, 1'b1);
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                mid();
                chk("vec_valid", ser_valid, 1'b1);
                chk("vec_bit",   ser_out,   vecs[v].seq[i]);
                chk("vec_first", ser_first, (i == 0));
                chk("vec_last",  ser_last,  (i == 7));
                chk("vec_done0", done,      1'b0);
                step();
            end
            mid();
            chk("vec_done", done,      1'b1);
            chk("vec_busy", busy,      1'b0);
            chk("vec_idle", ser_valid, 1'b0);
            step();
            mid();
            chk("vec_done_pulse", done, 1'b0);
            step();
            $display("vector %0d data=%02h msb_first=%0d checked", v, vecs[v].data, vecs[v].msb);
        end

        // Back-to-back: 8'h01 LSB-first then 8'h80 MSB-first, second goes to the hold buffer
        sq16 = 16'b1000_0000_1000_0000;
        in_valid = 1'b1; in_data = 8'h01; msb_first = 1'b0;
        step();
        in_data = 8'h80; msb_first = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) in_valid = 1'b0;
            mid();
            chk("b2b_valid", ser_valid, 1'b1);
            chk("b2b_bit",   ser_out,   sq16[c-1]);
            chk("b2b_ready", in_ready,  (c == 1) || (c >= 9));
            chk("b2b_first", ser_first, (c == 1) || (c == 9));
            chk("b2b_last",  ser_last,  (c == 8) || (c == 16));
            chk("b2b_busy",  busy,      1'b1);
            step();
        end
        mid();
        chk("b2b_done", done, 1'b1);
        chk("b2b_end",  busy, 1'b0);
        step();
        $display("back-to-back 01/80 checked");
        idle_cycles(2);

        // enb low for 3 cycles after bit 3 of 8'hC1
        sq = 8'b10000011;
        in_valid = 1'b1; in_data = 8'hC1; msb_first = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            enb = !(c >= 5 && c <= 7);
            mid();
            if (!enb) begin
                chk("frz_valid", ser_valid, 1'b0);
                chk("frz_bit",   ser_out,   sq[3]);
                chk("frz_last",  ser_last,  1'b0);
                chk("frz_ready", in_ready,  1'b0);
                chk("frz_busy",  busy,      1'b1);
            end else begin
                b = (c <= 4) ? c - 1 : c - 4;
                chk("frz_rvalid", ser_valid, 1'b1);
                chk("frz_rbit",   ser_out,   sq[b]);
                chk("frz_rfirst", ser_first, (b == 0));
                chk("frz_rlast",  ser_last,  (c == 11));
            end
            step();
        end
        enb = 1'b1;
        mid();
        chk("frz_done", done, 1'b1);
        step();
        $display("enable freeze on C1 checked");
        idle_cycles(2);

        // Reset pulse during bit 4 with a word held
        in_valid = 1'b1; in_data = 8'hA5; msb_first = 1'b0;
        step();
        in_data = 8'h3C; msb_first = 1'b1;
        step();
        in_valid = 1'b0;
        mid();
        chk("rp_held_ready", in_ready, 1'b0);
        step(); step(); step();
        rst = 1'b0;
        mid();
        chk("rp_valid", ser_valid, 1'b0);
        chk("rp_busy",  busy,      1'b0);
        chk("rp_ready", in_ready,  1'b0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("rp_nodone", done,      1'b0);
            chk("rp_idle",   busy,      1'b0);
            chk("rp_novld",  ser_valid, 1'b0);
            step();
        end
        in_valid = 1'b1; in_data = 8'hFF; msb_first = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("rp_ff_bit",   ser_out,   1'b1);
            chk("rp_ff_first", ser_first, (i == 0));
            chk("rp_ff_last",  ser_last,  (i == 7));
            step();
        end
        mid();
        chk("rp_ff_done", done, 1'b1);
        step();
        $display("reset pulse with held word checked");
        idle_cycles(20);

        // Randomized run against a queue of pending serial bits
        q.delete();
        prev_last = 1'b0;
        for (int c = 0; c < 600; c++) begin
            enb       = ($urandom_range(0, 7) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            msb_first = 1'($urandom_range(0, 1));
            // A word can be taken while fewer than two words are resident.
            exp_ready = enb && (((q.size() + DW - 1) / DW) < 2);
            mid();
            chk("rnd_ready", in_ready,  exp_ready);
            chk("rnd_valid", ser_valid, enb && (q.size() > 0));
            chk("rnd_busy",  busy,      (q.size() > 0));
            chk("rnd_done",  done,      enb && prev_last);
            if (q.size() > 0) chk("rnd_bit", ser_out, q[0].b);
            if (enb && q.size() > 0) begin
                chk("rnd_first", ser_first, q[0].f);
                chk("rnd_last",  ser_last,  q[0].l);
            end
            prev_last = enb && (q.size() > 0) && q[0].l;
            if (enb && q.size() > 0) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                for (int i = 0; i < DW; i++)
                    q.push_back('{b: (msb_first ? in_data[DW-1-i] : in_data[i]),
                                  f: (i == 0), l: (i == DW - 1)});
                $display("random word data=%02h msb_first=%0d accepted in cycle %0d", in_data, msb_first, c);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
